// File: rtl/crossbar_vc_reg.sv
// Registered VC crossbar: each output picks one of the other NUM_P-1 inputs and one VC of it,
// holding the flit in a single output register. Optional counters: define CROSSBAR_VC_STATS_EN.

module crossbar_vc_reg_lane #(
    parameter int NUM_P    = 5,
    parameter int NUM_V    = 2,
    parameter int W        = 32,
    parameter int PS_BITS  = 2,
    parameter int VS_BITS  = 1,
    parameter int SRC_BITS = 3,
    parameter int OP       = 0
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_P-1:0][NUM_V-1:0][W-1:0]  i_inport,
    input  logic [NUM_P-1:0][VS_BITS-1:0]       i_vc_sel,
    input  logic                                i_sel_valid,
    input  logic [PS_BITS-1:0]                  i_p_sel,
    input  logic                                i_out_ready,
    input  logic                                i_err_clr,
    output logic [W-1:0]                        o_outport,
    output logic                                o_out_valid,
    output logic                                o_sel_ready,
    output logic                                o_sel_err,
    output logic                                o_xfer,
    output logic [SRC_BITS-1:0]                 o_src
);
    logic                r_valid;
    logic                r_sel_err;
    logic [W-1:0]        r_data;
    logic                w_legal;
    logic                w_ready;
    logic                w_xfer;
    logic                w_bad;
    logic [SRC_BITS-1:0] w_src;
    logic [W-1:0]        w_flit;

    // Skip over our own port: p_sel values at or above OP map one index higher.
    always_comb begin
        w_legal = 1'b0;
        w_src   = '0;
        w_flit  = '0;
        for (int k = 0; k < NUM_P-1; k++) begin
            if (i_p_sel == PS_BITS'(k)) begin
                w_legal = 1'b1;
                w_src   = SRC_BITS'((k < OP) ? k : k + 1);
            end
        end
        for (int v = 0; v < NUM_V; v++) begin
            if (NUM_V == 1 || i_vc_sel[w_src] == VS_BITS'(v))
                w_flit = i_inport[w_src][v];
        end
    end

    assign w_ready = !r_valid || i_out_ready;
    assign w_xfer  = i_sel_valid && w_ready && w_legal;
    assign w_bad   = i_sel_valid && w_ready && !w_legal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_sel_err <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_valid <= 1'b1;
                r_data  <= w_flit;
            end else if (i_out_ready) begin
                r_valid <= 1'b0;
            end
            r_sel_err <= w_bad || (r_sel_err && !i_err_clr);
        end
    end

    assign o_outport   = r_data;
    assign o_out_valid = r_valid;
    assign o_sel_ready = w_ready;
    assign o_sel_err   = r_sel_err;
    assign o_xfer      = w_xfer;
    assign o_src       = w_src;
endmodule

module crossbar_vc_reg #(
    parameter  int NUM_P          = 5,
    parameter  int NUM_V          = 2,
    parameter  int PORT_BANDWIDTH = 32,
    localparam int PS_RAW         = $clog2(NUM_P-1),
    localparam int VS_RAW         = $clog2(NUM_V),
    localparam int PS_BITS        = (PS_RAW < 1) ? 1 : PS_RAW,
    localparam int VS_BITS        = (VS_RAW < 1) ? 1 : VS_RAW
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic [NUM_P-1:0][NUM_V-1:0][PORT_BANDWIDTH-1:0]  inport,
    input  logic [NUM_P-1:0][VS_BITS-1:0]                    vc_sel,
    input  logic [NUM_P-1:0]                                 sel_valid,
    input  logic [NUM_P-1:0][PS_BITS-1:0]                    p_sel,
    output logic [NUM_P-1:0]                                 sel_ready,
    output logic [NUM_P-1:0][PORT_BANDWIDTH-1:0]             outport,
    output logic [NUM_P-1:0]                                 out_valid,
    input  logic [NUM_P-1:0]                                 out_ready,
    input  logic                                             err_clr,
    output logic [NUM_P-1:0]                                 sel_err,
    output logic [NUM_P-1:0]                                 conflict_err
`ifdef CROSSBAR_VC_STATS_EN
    ,
    output logic [NUM_P-1:0][15:0]                           flit_cnt
`endif
);
    localparam int SRC_BITS = $clog2(NUM_P);

    logic [NUM_P-1:0]                w_xfer;
    logic [NUM_P-1:0][SRC_BITS-1:0]  w_src;
    logic [NUM_P-1:0]                w_seen;
    logic [NUM_P-1:0]                w_conf;
    logic [NUM_P-1:0]                r_conflict;

    for (genvar op = 0; op < NUM_P; op++) begin : g_lane
        crossbar_vc_reg_lane #(
            .NUM_P    (NUM_P),
            .NUM_V    (NUM_V),
            .W        (PORT_BANDWIDTH),
            .PS_BITS  (PS_BITS),
            .VS_BITS  (VS_BITS),
            .SRC_BITS (SRC_BITS),
            .OP       (op)
        ) u_lane (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_inport    (inport),
            .i_vc_sel    (vc_sel),
            .i_sel_valid (sel_valid[op]),
            .i_p_sel     (p_sel[op]),
            .i_out_ready (out_ready[op]),
            .i_err_clr   (err_clr),
            .o_outport   (outport[op]),
            .o_out_valid (out_valid[op]),
            .o_sel_ready (sel_ready[op]),
            .o_sel_err   (sel_err[op]),
            .o_xfer      (w_xfer[op]),
            .o_src       (w_src[op])
        );
    end

    // A source seen a second time in the same cycle is a replication conflict.
    always_comb begin
        w_seen = '0;
        w_conf = '0;
        for (int op = 0; op < NUM_P; op++) begin
            if (w_xfer[op]) begin
                if (w_seen[w_src[op]]) w_conf[w_src[op]] = 1'b1;
                w_seen[w_src[op]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_conflict <= '0;
        else        r_conflict <= w_conf | (err_clr ? '0 : r_conflict);
    end

    assign conflict_err = r_conflict;

`ifdef CROSSBAR_VC_STATS_EN
    logic [NUM_P-1:0][15:0] r_flit_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flit_cnt <= '0;
        end else begin
            for (int op = 0; op < NUM_P; op++) begin
                if (err_clr)
                    r_flit_cnt[op] <= (out_valid[op] && out_ready[op]) ? 16'd1 : 16'd0;
                else if (out_valid[op] && out_ready[op] && r_flit_cnt[op] != 16'hFFFF)
                    r_flit_cnt[op] <= r_flit_cnt[op] + 16'd1;
            end
        end
    end

    assign flit_cnt = r_flit_cnt;
`endif
endmodule

// File: tb/tb_crossbar_vc_reg.sv
// Bench for crossbar_vc_reg: table of grant patterns on a 5-port/2-VC instance checked through a
// per-output scoreboard, plus hand sequences for stall, reset, illegal select (4-port/1-VC instance).

module tb_crossbar_vc_reg;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance A: NUM_P=5, NUM_V=2, 32-bit
    logic [4:0][1:0][31:0] a_in;
    logic [4:0][0:0]       a_vs;
    logic [4:0]            a_sv;
    logic [4:0][1:0]       a_ps;
    logic [4:0]            a_srdy;
    logic [4:0][31:0]      a_out;
    logic [4:0]            a_ov;
    logic [4:0]            a_ordy;
    logic                  a_clr;
    logic [4:0]            a_serr;
    logic [4:0]            a_cerr;
`ifdef CROSSBAR_VC_STATS_EN
    logic [4:0][15:0]      a_cnt;
`endif

    // Instance B: NUM_P=4, NUM_V=1, 8-bit
    logic [3:0][0:0][7:0]  b_in;
    logic [3:0][0:0]       b_vs;
    logic [3:0]            b_sv;
    logic [3:0][1:0]       b_ps;
    logic [3:0]            b_srdy;
    logic [3:0][7:0]       b_out;
    logic [3:0]            b_ov;
    logic [3:0]            b_ordy;
    logic                  b_clr;
    logic [3:0]            b_serr;
    logic [3:0]            b_cerr;

    crossbar_vc_reg #(.NUM_P(5), .NUM_V(2), .PORT_BANDWIDTH(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .inport(a_in), .vc_sel(a_vs), .sel_valid(a_sv),
        .p_sel(a_ps), .sel_ready(a_srdy), .outport(a_out), .out_valid(a_ov),
        .out_ready(a_ordy), .err_clr(a_clr), .sel_err(a_serr), .conflict_err(a_cerr)
`ifdef CROSSBAR_VC_STATS_EN
        , .flit_cnt(a_cnt)
`endif
    );

    crossbar_vc_reg #(.NUM_P(4), .NUM_V(1), .PORT_BANDWIDTH(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .inport(b_in), .vc_sel(b_vs), .sel_valid(b_sv),
        .p_sel(b_ps), .sel_ready(b_srdy), .outport(b_out), .out_valid(b_ov),
        .out_ready(b_ordy), .err_clr(b_clr), .sel_err(b_serr), .conflict_err(b_cerr)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model for instance A
    logic [4:0]  m_valid;
    logic [4:0]  m_conf;
    logic [31:0] hold [5];
    logic [31:0] q [5][$];

    task automatic randomize_a();
        for (int s = 0; s < 5; s++)
            for (int v = 0; v < 2; v++) a_in[s][v] = $urandom;
    endtask

    // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
    task automatic do_cycle();
        logic [4:0] rdy, ld, set;
        int cnt [5];
        int p, src;
        #1;
        rdy = ~m_valid | a_ordy;
        chk("A.sel_ready", a_srdy, rdy);
        ld  = a_sv & rdy;
        set = '0;
        for (int s = 0; s < 5; s++) cnt[s] = 0;
        for (int op = 0; op < 5; op++) begin
            if (ld[op]) begin
                p   = int'(a_ps[op]);
                src = (p < op) ? p : p + 1;
                q[op].push_back(a_in[src][a_vs[src]]);
                cnt[src]++;
            end
        end
        for (int s = 0; s < 5; s++) if (cnt[s] >= 2) set[s] = 1'b1;
        m_valid = ld | (m_valid & ~a_ordy);
        m_conf  = set | (a_clr ? 5'b0 : m_conf);
        @(posedge clk); #1;
        chk("A.out_valid", a_ov, m_valid);
        chk("A.conflict_err", a_cerr, m_conf);
        chk("A.sel_err", a_serr, 5'b0);
        for (int op = 0; op < 5; op++) begin
            if (ld[op]) begin
                if (q[op].size() == 0) chk("A.scoreboard_underflow", 0, 1);
                else hold[op] = q[op].pop_front();
            end
            if (m_valid[op]) chk($sformatf("A.outport[%0d]", op), a_out[op], hold[op]);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [4:0]      sv;
        logic [4:0][1:0] ps;   // {op4, op3, op2, op1, op0}
        logic [4:0]      vs;
        logic [4:0]      ev;
        logic [4:0]      ec;
    } vec_t;

    vec_t tbl [6];

    initial begin
        #1_500_000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] bexp;

        tbl[0] = '{5'b00001, {2'd0, 2'd0, 2'd0, 2'd0, 2'd1}, 5'b00100, 5'b00001, 5'b00000};
        tbl[1] = '{5'b10010, {2'd3, 2'd0, 2'd0, 2'd3, 2'd0}, 5'b11000, 5'b10010, 5'b00000};
        tbl[2] = '{5'b01001, {2'd0, 2'd2, 2'd0, 2'd0, 2'd1}, 5'b00000, 5'b01001, 5'b00100};
        tbl[3] = '{5'b11111, {2'd0, 2'd0, 2'd0, 2'd0, 2'd0}, 5'b10101, 5'b11111, 5'b00001};
        tbl[4] = '{5'b11111, {2'd2, 2'd3, 2'd2, 2'd0, 2'd0}, 5'b01010, 5'b11111, 5'b00000};
        tbl[5] = '{5'b00000, {2'd0, 2'd0, 2'd0, 2'd0, 2'd0}, 5'b00000, 5'b00000, 5'b00000};

        rst_n = 1'b0;
        a_in = '0; a_vs = '0; a_sv = '0; a_ps = '0; a_ordy = '0; a_clr = 1'b0;
        b_in = '0; b_vs = '0; b_sv = '0; b_ps = '0; b_ordy = '0; b_clr = 1'b0;
        m_valid = '0; m_conf = '0;
        for (int i = 0; i < 5; i++) hold[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.out_valid", a_ov, 5'b0);
        chk("reset.sel_ready", a_srdy, 5'b11111);
        chk("reset.outport_zero", (a_out == '0), 1);
        chk("reset.conflict_err", a_cerr, 5'b0);
        chk("reset.sel_err", a_serr, 5'b0);
        chk("reset.B_out_valid", b_ov, 4'b0);
        rst_n = 1'b1;

        // Table of grant patterns, each drained the following row
        for (int i = 0; i < 6; i++) begin
            randomize_a();
            if (i == 0) a_in[2][1] = 32'hA5A5_0001;
            a_sv = tbl[i].sv; a_ps = tbl[i].ps;
            for (int s = 0; s < 5; s++) a_vs[s] = tbl[i].vs[s];
            a_ordy = '1; a_clr = 1'b1;
            do_cycle();
            chk($sformatf("table%0d.out_valid", i), a_ov, tbl[i].ev);
            chk($sformatf("table%0d.conflict_err", i), a_cerr, tbl[i].ec);
            if (i == 0) chk("table0.outport0_A5A50001", a_out[0], 32'hA5A5_0001);
        end
        a_clr = 1'b0;

        // Stall on op3: held flit stays put for 4 cycles, then replaced with no bubble
        randomize_a();
        a_sv = 5'b01000; a_ps = '0; a_ordy = '1;
        do_cycle();
        randomize_a();
        a_ordy[3] = 1'b0; a_ps[3] = 2'd1;
        for (int c = 0; c < 4; c++) begin
            do_cycle();
            chk("stall.sel_ready3", a_srdy[3], 1'b0);
        end
        a_ordy[3] = 1'b1;
        do_cycle();
        chk("stall.no_bubble_valid3", a_ov[3], 1'b1);
        chk("stall.new_flit3", a_out[3], a_in[1][a_vs[1]]);
        a_sv = '0;
        do_cycle();

        // Reset mid-stall with out_valid=10110
        randomize_a();
        a_ordy = '0; a_sv = 5'b10110; a_ps = {2'd1, 2'd0, 2'd2, 2'd0, 2'd0};
        do_cycle();
        a_sv = '0;
        do_cycle();
        chk("prereset.out_valid", a_ov, 5'b10110);
        rst_n = 1'b0;
        #1;
        chk("async_reset.out_valid", a_ov, 5'b0);
        chk("async_reset.sel_ready", a_srdy, 5'b11111);
        chk("async_reset.outport_zero", (a_out == '0), 1);
        m_valid = '0; m_conf = '0;
        for (int i = 0; i < 5; i++) q[i].delete();
        step();
        rst_n = 1'b1;
        randomize_a();
        a_sv = 5'b00001; a_ps = '0; a_ps[0] = 2'd1; a_ordy = '1;
        do_cycle();
        chk("post_reset.first_transfer", a_ov[0], 1'b1);
        a_sv = '0;
        do_cycle();

        // Instance B: illegal p_sel=3 on op2, sticky sel_err, err_clr priority
        b_ordy = '1; b_sv = 4'b0100; b_ps = '0; b_ps[2] = 2'd3;
        step();
        chk("B.illegal_no_xfer", b_ov, 4'b0);
        chk("B.sel_err_set", b_serr, 4'b0100);
        b_sv = '0;
        step(); step();
        chk("B.sel_err_sticky", b_serr, 4'b0100);
        b_clr = 1'b1;
        step();
        chk("B.sel_err_cleared", b_serr, 4'b0);
        b_sv = 4'b0100;
        step();
        chk("B.set_beats_clear", b_serr, 4'b0100);
        b_sv = '0;
        step();
        chk("B.sel_err_cleared2", b_serr, 4'b0);
        b_clr = 1'b0;

        // Instance B: single VC ignores vc_sel; op1 p_sel=1 selects input 2
        for (int s = 0; s < 4; s++) b_in[s][0] = 8'($urandom);
        b_vs = '1; b_sv = 4'b0010; b_ps = '0; b_ps[1] = 2'd1;
        bexp = b_in[2][0];
        step();
        chk("B.single_vc_valid", b_ov, 4'b0010);
        chk("B.single_vc_data", b_out[1], bexp);

        // Instance B: illegal grant while stalled is ignored
        b_sv = 4'b0100; b_ps = '0; b_ordy[2] = 1'b0;
        step();
        b_ps[2] = 2'd3;
        step();
        chk("B.stalled_illegal_no_err", b_serr, 4'b0);
        chk("B.stalled_holds", b_ov[2], 1'b1);
        chk("B.no_conflict", b_cerr, 4'b0);
        b_sv = '0; b_ordy = '1;
        step();

`ifdef CROSSBAR_VC_STATS_EN
        a_sv = 5'b00010; a_ps = '0; a_ordy = '1; a_clr = 1'b1;
        step();
        a_clr = 1'b0;
        chk("stats.cleared_op0", a_cnt[0], 16'h0);
        repeat (70001) @(posedge clk);
        #1;
        chk("stats.saturate_op1", a_cnt[1], 16'hFFFF);
        a_clr = 1'b1;
        step();
        chk("stats.clear_with_handshake", a_cnt[1], 16'h1);
        a_clr = 1'b0; a_sv = '0;
        step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
